if_fetch_ctrl: RTL and testbench
================================

// Module: if_fetch_ctrl
// PURPOSE
//  IF-stage fetch controller: holds the PC and runs the req/ack handshake to instruction
//  memory. Presents fetched {pc,inst} to IF_ID through a 1-entry valid/ready slot.
//  Consumes branch_info_if (branch/jump redirects) driven by the ID/EX pipeline register.
//  Flushes the slot and discards in-flight fetch data on a redirect.
// PARAMETERS
//  RESET_PC  32'h1c00_0000  first fetch address after reset
//  ADDR_W    32             address width
//  DATA_W    32             instruction width
// PORTS
//  clk          in   1       clock
//  rst          in   1       reset, synchronous, active-high
//  branch_en    in   1       branch redirect valid (branch_info_if)
//  branch_addr  in   ADDR_W  branch target
//  jump_en      in   1       jump redirect valid (branch_info_if)
//  jump_addr    in   ADDR_W  jump target
//  imem_req     out  1       fetch request, held high until imem_ack
//  imem_addr    out  ADDR_W  fetch address (= pc register)
//  imem_ack     in   1       request accepted, imem_rdata valid this cycle
//  imem_rdata   in   DATA_W  fetched instruction
//  out_valid    out  1       slot holds a valid instruction
//  out_pc       out  ADDR_W  pc of slot instruction
//  out_inst     out  DATA_W  slot instruction
//  out_ready    in   1       IF_ID accepts slot (out_valid&&out_ready = transfer)
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=IDLE, tgt_q=0, imem_req=0, out_valid=0, out_pc=0, out_inst=0.
//  Reset overrides everything incl. an outstanding request (its later ack is ignored).
//  redirect = jump_en|branch_en; target = jump_en ? jump_addr : branch_addr (jump wins);
//   target[1:0] forced to 2'b00.
//  imem_req = (state!=IDLE), registered; imem_addr = pc; both stable while req&&!ack.
//  States:
//   IDLE: no request. redirect -> pc<=target, out_valid<=0, stay IDLE.
//         else if (!out_valid || out_ready) -> REQ.
//   REQ:  req high. ack && !redirect -> out_pc<=pc, out_inst<=imem_rdata, out_valid<=1,
//         pc<=pc+4 (mod 2^ADDR_W), -> IDLE.
//         ack && redirect -> data dropped, pc<=target, out_valid<=0, -> IDLE.
//         !ack && redirect -> tgt_q<=target, out_valid<=0, -> DISC.
//   DISC: req high, same pc (request cannot be withdrawn). redirect -> tgt_q/out_valid
//         updated as above. ack -> data dropped, pc<=(redirect ? target : tgt_q), -> IDLE.
//  Slot: out_valid clears on transfer when not reloaded; since REQ only entered with the slot
//   empty or draining, slot is always empty at ack (no overwrite possible).
//  Redirect always clears out_valid next cycle, even if out_ready is high the same cycle
//   (the transfer in that cycle still completes).
//  Latency: zero-wait memory -> one instruction per 2 cycles (IDLE,REQ). First imem_req high
//   1 cycle after rst falls; first out_valid 1 cycle after first ack.
//  Redirect penalty: target fetch issued 1 cycle after redirect (IDLE) or after pending ack.
// TESTING
//  1 Reset release, ack every req cycle, out_ready=1 -> imem_addr 1c000000,1c000004,
//    1c000008; out_pc matches; req high cycle 1, out_valid cycle 2.
//  2 out_ready=0 for 5 cycles with out_valid=1 -> imem_req stays 0, out_pc/out_inst stable,
//    pc unchanged; next fetch issued 1 cycle after out_ready rises.
//  3 Redirect jump_addr=1c000100 while req pending, ack 3 cycles later with rdata=DEADBEEF ->
//    DEADBEEF never appears on out_*; next imem_addr=1c000100.
//  4 branch_en&jump_en same cycle (branch 1c000200, jump 1c000300) -> next pc 1c000300;
//    branch_addr=1c000207 alone -> imem_addr 1c000204.
//  5 Redirect in same cycle as ack -> rdata dropped, out_valid=0, next req to target.
//  6 rst asserted mid-REQ, stale ack during reset -> all outputs at reset values; first
//    post-reset fetch at RESET_PC; pc FFFFFFFC + ack wraps to 00000000.

Source files
------------

// File: rtl/if_fetch_ctrl_if.sv
// Bundle of fetch-controller signals: redirect inputs, instruction-memory handshake and IF_ID slot.
// master = fetch controller, slave = surrounding pipeline/memory.
interface if_fetch_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              branch_en;
  logic [ADDR_W-1:0] branch_addr;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  logic              out_valid;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_inst;
  logic              out_ready;

  modport master (
    input  branch_en, branch_addr, jump_en, jump_addr,
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output out_valid, out_pc, out_inst,
    input  out_ready
  );

  modport slave (
    output branch_en, branch_addr, jump_en, jump_addr,
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  out_valid, out_pc, out_inst,
    output out_ready
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: owns the PC, runs the imem req/ack handshake and feeds a
// one-entry {pc,inst} slot to IF_ID; branch/jump redirects flush the slot and in-flight data.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000,
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DISC
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_tgt_q;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_pc;
  logic [DATA_W-1:0] r_out_inst;

  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_tgt_nxt;
  logic              w_out_valid_nxt;
  logic [ADDR_W-1:0] w_out_pc_nxt;
  logic [DATA_W-1:0] w_out_inst_nxt;

  logic              w_redirect;
  logic [ADDR_W-1:0] w_target_raw;
  logic [ADDR_W-1:0] w_target;

  // Jump has priority over branch; targets are always word aligned.
  assign w_redirect   = bus.jump_en | bus.branch_en;
  assign w_target_raw = bus.jump_en ? bus.jump_addr : bus.branch_addr;
  assign w_target     = {w_target_raw[ADDR_W-1:2], 2'b00};

  assign bus.imem_req  = (r_state != S_IDLE);
  assign bus.imem_addr = r_pc;
  assign bus.out_valid = r_out_valid;
  assign bus.out_pc    = r_out_pc;
  assign bus.out_inst  = r_out_inst;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_tgt_nxt       = r_tgt_q;
    w_out_valid_nxt = r_out_valid && !bus.out_ready;
    w_out_pc_nxt    = r_out_pc;
    w_out_inst_nxt  = r_out_inst;

    unique case (r_state)
      S_IDLE: begin
        if (w_redirect) begin
          w_pc_nxt        = w_target;
          w_out_valid_nxt = 1'b0;
        end else if (!r_out_valid || bus.out_ready) begin
          w_state_nxt = S_REQ;
        end
      end

      S_REQ: begin
        if (bus.imem_ack) begin
          w_state_nxt = S_IDLE;
          if (w_redirect) begin
            w_pc_nxt        = w_target;
            w_out_valid_nxt = 1'b0;
          end else begin
            // Slot is guaranteed empty or draining here, so loading never overwrites.
            w_out_pc_nxt    = r_pc;
            w_out_inst_nxt  = bus.imem_rdata;
            w_out_valid_nxt = 1'b1;
            w_pc_nxt        = r_pc + ADDR_W'(4);
          end
        end else if (w_redirect) begin
          w_tgt_nxt       = w_target;
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_DISC;
        end
      end

      S_DISC: begin
        // The request cannot be withdrawn: wait for its ack and throw the data away.
        if (w_redirect) begin
          w_tgt_nxt       = w_target;
          w_out_valid_nxt = 1'b0;
        end
        if (bus.imem_ack) begin
          w_pc_nxt    = w_redirect ? w_target : r_tgt_q;
          w_state_nxt = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= ADDR_W'(RESET_PC);
      r_tgt_q     <= '0;
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_inst  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_tgt_q     <= w_tgt_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_pc    <= w_out_pc_nxt;
      r_out_inst  <= w_out_inst_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: accepted fetches are pushed to a scoreboard and popped
// on every slot transfer; handshake, stall, redirect, reset and wrap cases are checked inline.
module tb_if_fetch_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [63:0] sb[$];

  if_fetch_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  if_fetch_ctrl #(
    .RESET_PC(32'h1c00_0000),
    .ADDR_W  (32),
    .DATA_W  (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scores any transfer happening this cycle, then advances to just after the next edge.
  task automatic tick();
    logic [63:0] exp;
    if (bus.out_valid && bus.out_ready) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        check("xfer_pc", 64'(bus.out_pc), 64'(exp[63:32]));
        check("xfer_inst", 64'(bus.out_inst), 64'(exp[31:0]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic expect_req(input string tag, input logic [31:0] addr);
    check({tag, "_req"}, 64'(bus.imem_req), 64'd1);
    check({tag, "_addr"}, 64'(bus.imem_addr), 64'(addr));
  endtask

  // Acks the pending request with an instruction that must reach the slot.
  task automatic fetch(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    expect_req(tag, pc);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = inst;
    sb.push_back({pc, inst});
    tick();
    bus.imem_ack = 1'b0;
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_slot_pc"}, 64'(bus.out_pc), 64'(pc));
    check({tag, "_idle"}, 64'(bus.imem_req), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 64'(bus.imem_req), 64'd0);
    check({tag, "_addr"}, 64'(bus.imem_addr), 64'h1c00_0000);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_pc"}, 64'(bus.out_pc), 64'd0);
    check({tag, "_inst"}, 64'(bus.out_inst), 64'd0);
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst             = 1'b1;
    bus.branch_en   = 1'b0;
    bus.branch_addr = '0;
    bus.jump_en     = 1'b0;
    bus.jump_addr   = '0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = '0;
    bus.out_ready   = 1'b1;

    // 1: reset release and back-to-back fetches
    repeat (3) tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    check("rel_req_low", 64'(bus.imem_req), 64'd0);
    tick();
    fetch("f0", 32'h1c00_0000, 32'h1111_0000);
    tick();
    fetch("f1", 32'h1c00_0004, 32'h1111_0004);
    tick();
    fetch("f2", 32'h1c00_0008, 32'h1111_0008);
    tick();

    // 2: IF_ID back-pressure holds the slot and blocks fetching
    bus.out_ready = 1'b0;
    fetch("f3", 32'h1c00_000c, 32'h1111_000c);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_req", 64'(bus.imem_req), 64'd0);
      check("stall_valid", 64'(bus.out_valid), 64'd1);
      check("stall_pc", 64'(bus.out_pc), 64'h1c00_000c);
      check("stall_inst", 64'(bus.out_inst), 64'h1111_000c);
      check("stall_addr", 64'(bus.imem_addr), 64'h1c00_0010);
    end
    bus.out_ready = 1'b1;
    tick();
    expect_req("resume", 32'h1c00_0010);

    // 3: jump while request pending; late ack data is discarded
    bus.jump_en   = 1'b1;
    bus.jump_addr = 32'h1c00_0100;
    tick();
    bus.jump_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expect_req("disc_hold", 32'h1c00_0010);
      check("disc_valid", 64'(bus.out_valid), 64'd0);
      tick();
    end
    expect_req("disc_hold", 32'h1c00_0010);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hdead_beef;
    tick();
    bus.imem_ack = 1'b0;
    check("disc_drop_valid", 64'(bus.out_valid), 64'd0);
    check("disc_drop_req", 64'(bus.imem_req), 64'd0);
    tick();

    // 4: jump beats branch; a slot transfer in the redirect cycle still completes
    fetch("f4", 32'h1c00_0100, 32'h2222_0100);
    bus.branch_en   = 1'b1;
    bus.branch_addr = 32'h1c00_0200;
    bus.jump_en     = 1'b1;
    bus.jump_addr   = 32'h1c00_0300;
    tick();
    bus.branch_en = 1'b0;
    bus.jump_en   = 1'b0;
    check("both_valid", 64'(bus.out_valid), 64'd0);
    check("both_req", 64'(bus.imem_req), 64'd0);
    tick();
    expect_req("jump_wins", 32'h1c00_0300);
    bus.branch_en   = 1'b1;
    bus.branch_addr = 32'h1c00_0207;
    tick();
    bus.branch_en  = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hbadc_0de0;
    tick();
    bus.imem_ack = 1'b0;
    check("align_valid", 64'(bus.out_valid), 64'd0);
    tick();
    expect_req("align", 32'h1c00_0204);

    // 5: redirect coincident with ack
    bus.imem_ack    = 1'b1;
    bus.imem_rdata  = 32'h5555_aaaa;
    bus.branch_en   = 1'b1;
    bus.branch_addr = 32'h1c00_0400;
    tick();
    bus.imem_ack  = 1'b0;
    bus.branch_en = 1'b0;
    check("coinc_valid", 64'(bus.out_valid), 64'd0);
    check("coinc_req", 64'(bus.imem_req), 64'd0);
    tick();
    expect_req("coinc_tgt", 32'h1c00_0400);

    // 6: reset mid-request with a stale ack, then address wrap
    rst = 1'b1;
    tick();
    check_reset_outputs("mid_rst");
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hdead_beef;
    tick();
    bus.imem_ack = 1'b0;
    check_reset_outputs("stale_ack");
    rst = 1'b0;
    tick();
    fetch("f5", 32'h1c00_0000, 32'h3333_0000);
    bus.jump_en   = 1'b1;
    bus.jump_addr = 32'hffff_fffc;
    tick();
    bus.jump_en = 1'b0;
    tick();
    fetch("f6", 32'hffff_fffc, 32'h4444_fffc);
    tick();
    expect_req("wrap", 32'h0000_0000);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
